hockey_display: RTL and testbench



---
 rtl/hockey_pkg.sv | 42 ++++
 rtl/hockey_display_seg7_encode.sv | 26 ++
 rtl/hockey_display.sv | 173 +++++++++++++++++
 tb/tb_hockey_display.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hockey_pkg.sv
// hockey_pkg
// Shared definitions for the air-hockey display path:
//   - state codes driven by the game FSM (shared with that FSM),
//   - active-low 7-segment glyphs, bit order {g,f,e,d,c,b,a},
//   - a helper that turns a puck column into a one-hot LED pattern.
package hockey_pkg;

    // Game FSM state codes; 11..15 are unused and shown as a dark display.
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_DISPLAY  = 4'd1;
    localparam logic [3:0] ST_HIT_A    = 4'd2;
    localparam logic [3:0] ST_HIT_B    = 4'd3;
    localparam logic [3:0] ST_SEND_A   = 4'd4;
    localparam logic [3:0] ST_SEND_B   = 4'd5;
    localparam logic [3:0] ST_RESP_A   = 4'd6;
    localparam logic [3:0] ST_RESP_B   = 4'd7;
    localparam logic [3:0] ST_GOAL_A   = 4'd8;
    localparam logic [3:0] ST_GOAL_B   = 4'd9;
    localparam logic [3:0] ST_GAMEOVER = 4'd10;

    // Digit glyphs.
    localparam logic [6:0] DIGIT_0 = 7'b1000000;
    localparam logic [6:0] DIGIT_1 = 7'b1111001;
    localparam logic [6:0] DIGIT_2 = 7'b0100100;
    localparam logic [6:0] DIGIT_3 = 7'b0110000;
    localparam logic [6:0] DIGIT_4 = 7'b0011001;
    localparam logic [6:0] DIGIT_5 = 7'b0010010;
    localparam logic [6:0] DIGIT_6 = 7'b0000010;
    localparam logic [6:0] DIGIT_7 = 7'b1111000;

    // Letter and punctuation glyphs.
    localparam logic [6:0] GLYPH_A     = 7'b0001000;
    localparam logic [6:0] GLYPH_B     = 7'b0000011;
    localparam logic [6:0] GLYPH_DASH  = 7'b0111111;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    // Puck column 0..4 -> one-hot LED column; off-board columns light nothing.
    function automatic logic [4:0] col_onehot(input logic [2:0] col);
        col_onehot = (col <= 3'd4) ? (5'b00001 << col) : 5'b00000;
    endfunction

endpackage

// File: rtl/hockey_display_seg7_encode.sv
// seg7_encode
// Combinational 3-bit value -> active-low 7-segment digit glyph.
// Ports:
//   value  in  [2:0]  value to show (0..7, every code has a glyph)
//   glyph  out [6:0]  active-low segments {g,f,e,d,c,b,a}
module seg7_encode
    import hockey_pkg::*;
(
    input  logic [2:0] value,
    output logic [6:0] glyph
);

    always_comb begin
        case (value)
            3'd0:    glyph = DIGIT_0;
            3'd1:    glyph = DIGIT_1;
            3'd2:    glyph = DIGIT_2;
            3'd3:    glyph = DIGIT_3;
            3'd4:    glyph = DIGIT_4;
            3'd5:    glyph = DIGIT_5;
            3'd6:    glyph = DIGIT_6;
            default: glyph = DIGIT_7;
        endcase
    end

endmodule

// File: rtl/hockey_display.sv
// hockey_display
// Display stage behind the air-hockey game FSM. Every output is a register
// loaded from the inputs sampled at the same edge and the blink phase that
// edge produces, so a new state is shown ON on its very first visible cycle.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   state   in  [3:0]   game state code (see hockey_pkg)
//   score_a in  [2:0]   player A score
//   score_b in  [2:0]   player B score
//   x_coord in  [2:0]   puck column 0..4
//   y_coord in  [2:0]   puck row 0..4
//   turn    in          serving player in DISPLAY (0=A, 1=B)
//   LEDA, LEDB out      player indicators
//   LEDX    out [4:0]   one-hot puck column
//   SSD7..SSD0 out [6:0] active-low digits {g,f,e,d,c,b,a}
module hockey_display
    import hockey_pkg::*;
#(
    parameter int BLINK_HALF = 100,
    parameter int WIN_SCORE  = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] state,
    input  logic [2:0] score_a,
    input  logic [2:0] score_b,
    input  logic [2:0] x_coord,
    input  logic [2:0] y_coord,
    input  logic       turn,
    output logic       LEDA,
    output logic       LEDB,
    output logic [4:0] LEDX,
    output logic [6:0] SSD7,
    output logic [6:0] SSD6,
    output logic [6:0] SSD5,
    output logic [6:0] SSD4,
    output logic [6:0] SSD3,
    output logic [6:0] SSD2,
    output logic [6:0] SSD1,
    output logic [6:0] SSD0
);

    localparam logic [15:0] BLINK_LAST = 16'(BLINK_HALF - 1);

    logic [3:0]  state_q;
    logic [15:0] blink_cnt, blink_cnt_next;
    logic        blink_phase, phase_next;

    logic [6:0] glyph_a, glyph_b, glyph_y;

    logic            leda_next, ledb_next;
    logic [4:0]      ledx_next;
    logic [7:0][6:0] ssd_next;
    logic            winner_a;

    seg7_encode u_enc_a (.value(score_a), .glyph(glyph_a));
    seg7_encode u_enc_b (.value(score_b), .glyph(glyph_b));
    seg7_encode u_enc_y (.value(y_coord), .glyph(glyph_y));

    // Blink generator next state. A state change restarts the half-period
    // in the ON phase and overrides any terminal-count toggle.
    always_comb begin
        if (state != state_q) begin
            blink_cnt_next = '0;
            phase_next     = 1'b1;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt_next = '0;
            phase_next     = ~blink_phase;
        end else begin
            blink_cnt_next = blink_cnt + 16'd1;
            phase_next     = blink_phase;
        end
    end

    assign winner_a = int'(score_a) >= WIN_SCORE;

    // Output decode.
    // NOTE: every signal gets a default at the top so no path through the
    // case leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        leda_next = 1'b0;
        ledb_next = 1'b0;
        ledx_next = 5'b00000;
        ssd_next  = {8{GLYPH_BLANK}};

        // Score line shared by every active game state.
        if (state >= ST_DISPLAY && state <= ST_GOAL_B) begin
            ssd_next[3] = glyph_a;
            ssd_next[2] = GLYPH_DASH;
            ssd_next[1] = GLYPH_DASH;
            ssd_next[0] = glyph_b;
        end

        case (state)
            ST_IDLE: begin
                ssd_next[3] = GLYPH_A;
                ssd_next[2] = GLYPH_DASH;
                ssd_next[1] = GLYPH_DASH;
                ssd_next[0] = GLYPH_B;
                leda_next   = phase_next;
                ledb_next   = phase_next;
            end
            ST_DISPLAY: begin
                leda_next = ~turn;
                ledb_next = turn;
            end
            ST_HIT_A: leda_next = 1'b1;
            ST_HIT_B: ledb_next = 1'b1;
            ST_SEND_A, ST_SEND_B, ST_RESP_A, ST_RESP_B: begin
                ssd_next[7] = (y_coord <= 3'd4) ? glyph_y : GLYPH_DASH;
                ledx_next   = col_onehot(x_coord);
                // Codes 4/6 have bit0 clear: A must respond.
                leda_next   = ~state[0];
                ledb_next   = state[0];
            end
            ST_GOAL_A: begin
                if (!phase_next) ssd_next[3] = GLYPH_BLANK;
                ledx_next = {5{phase_next}};
                leda_next = 1'b1;
            end
            ST_GOAL_B: begin
                if (!phase_next) ssd_next[0] = GLYPH_BLANK;
                ledx_next = {5{phase_next}};
                ledb_next = 1'b1;
            end
            ST_GAMEOVER: begin
                if (phase_next) ssd_next = {8{winner_a ? GLYPH_A : GLYPH_B}};
                leda_next = winner_a;
                ledb_next = ~winner_a;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Reset copy of the state is IDLE, so leaving reset into any
            // other state restarts the blink in the ON phase.
            state_q     <= ST_IDLE;
            blink_cnt   <= '0;
            blink_phase <= 1'b1;
            LEDA        <= 1'b0;
            LEDB        <= 1'b0;
            LEDX        <= 5'b00000;
            SSD7        <= GLYPH_BLANK;
            SSD6        <= GLYPH_BLANK;
            SSD5        <= GLYPH_BLANK;
            SSD4        <= GLYPH_BLANK;
            SSD3        <= GLYPH_BLANK;
            SSD2        <= GLYPH_BLANK;
            SSD1        <= GLYPH_BLANK;
            SSD0        <= GLYPH_BLANK;
        end else begin
            state_q     <= state;
            blink_cnt   <= blink_cnt_next;
            blink_phase <= phase_next;
            LEDA        <= leda_next;
            LEDB        <= ledb_next;
            LEDX        <= ledx_next;
            SSD7        <= ssd_next[7];
            SSD6        <= ssd_next[6];
            SSD5        <= ssd_next[5];
            SSD4        <= ssd_next[4];
            SSD3        <= ssd_next[3];
            SSD2        <= ssd_next[2];
            SSD1        <= ssd_next[1];
            SSD0        <= ssd_next[0];
        end
    end

endmodule

// File: tb/tb_hockey_display.sv
// tb_hockey_display
// Self-checking bench for hockey_display: directed scenarios followed by
// randomized state/score/puck traffic, all compared every cycle against a
// behavioural model that tracks "cycles spent in the current state" and
// derives the blink phase from it arithmetically.
module tb_hockey_display;

    localparam int BH  = 100;
    localparam int WIN = 3;

    localparam logic [6:0] G_A     = 7'b0001000;
    localparam logic [6:0] G_B     = 7'b0000011;
    localparam logic [6:0] G_DASH  = 7'b0111111;
    localparam logic [6:0] G_BLANK = 7'b1111111;

    typedef struct packed {
        logic            leda;
        logic            ledb;
        logic [4:0]      ledx;
        logic [7:0][6:0] ssd;
    } out_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] state = 4'd0;
    logic [2:0] score_a = 3'd0, score_b = 3'd0, x_coord = 3'd0, y_coord = 3'd0;
    logic       turn = 1'b0;
    logic       LEDA, LEDB;
    logic [4:0] LEDX;
    logic [6:0] SSD7, SSD6, SSD5, SSD4, SSD3, SSD2, SSD1, SSD0;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;

    // Model state: cycles since entering the current state (or reset).
    int   age        = 0;
    int   prev_state = 0;
    out_t exp_out;

    hockey_display #(.BLINK_HALF(BH), .WIN_SCORE(WIN)) dut (
        .clk(clk), .rst(rst), .state(state),
        .score_a(score_a), .score_b(score_b),
        .x_coord(x_coord), .y_coord(y_coord), .turn(turn),
        .LEDA(LEDA), .LEDB(LEDB), .LEDX(LEDX),
        .SSD7(SSD7), .SSD6(SSD6), .SSD5(SSD5), .SSD4(SSD4),
        .SSD3(SSD3), .SSD2(SSD2), .SSD1(SSD1), .SSD0(SSD0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s @cycle %0d: got=%h want=%h", tag, cycle, got, want);
        end
    endtask

    function automatic logic [6:0] digit(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            default: return 7'b1111000;
        endcase
    endfunction

    function automatic out_t model(input int st, input int sa, input int sb,
                                   input int x, input int y, input bit tn, input bit ph);
        out_t o;
        o.leda = 1'b0;
        o.ledb = 1'b0;
        o.ledx = 5'b00000;
        for (int i = 0; i < 8; i++) o.ssd[i] = G_BLANK;
        if (st >= 1 && st <= 9) begin
            o.ssd[3] = digit(sa);
            o.ssd[2] = G_DASH;
            o.ssd[1] = G_DASH;
            o.ssd[0] = digit(sb);
        end
        case (st)
            0: begin
                o.ssd[3] = G_A; o.ssd[2] = G_DASH; o.ssd[1] = G_DASH; o.ssd[0] = G_B;
                o.leda = ph; o.ledb = ph;
            end
            1: begin o.leda = !tn; o.ledb = tn; end
            2: o.leda = 1'b1;
            3: o.ledb = 1'b1;
            4, 5, 6, 7: begin
                o.ssd[7] = (y <= 4) ? digit(y) : G_DASH;
                o.ledx   = (x <= 4) ? 5'(1 << x) : 5'b00000;
                if (st == 4 || st == 6) o.leda = 1'b1;
                else                    o.ledb = 1'b1;
            end
            8: begin
                if (!ph) o.ssd[3] = G_BLANK;
                o.ledx = ph ? 5'b11111 : 5'b00000;
                o.leda = 1'b1;
            end
            9: begin
                if (!ph) o.ssd[0] = G_BLANK;
                o.ledx = ph ? 5'b11111 : 5'b00000;
                o.ledb = 1'b1;
            end
            10: begin
                bit a_wins;
                a_wins = (sa >= WIN);
                for (int i = 0; i < 8; i++) o.ssd[i] = ph ? (a_wins ? G_A : G_B) : G_BLANK;
                o.leda = a_wins;
                o.ledb = !a_wins;
            end
            default: ;
        endcase
        return o;
    endfunction

    // One clock edge: update the model with the inputs the edge samples,
    // then compare every output shortly after the edge.
    task automatic tick();
        bit ph;
        @(posedge clk);
        cycle++;
        if (rst) begin
            age        = 0;
            prev_state = 0;
            exp_out.leda = 1'b0;
            exp_out.ledb = 1'b0;
            exp_out.ledx = 5'b00000;
            for (int i = 0; i < 8; i++) exp_out.ssd[i] = G_BLANK;
        end else begin
            if (int'(state) != prev_state) age = 0;
            else                           age++;
            prev_state = int'(state);
            ph = ((age / BH) % 2) == 0;
            exp_out = model(int'(state), int'(score_a), int'(score_b),
                            int'(x_coord), int'(y_coord), turn, ph);
        end
        #1;
        check("LEDA", 32'(LEDA), 32'(exp_out.leda));
        check("LEDB", 32'(LEDB), 32'(exp_out.ledb));
        check("LEDX", 32'(LEDX), 32'(exp_out.ledx));
        check("SSD7", 32'(SSD7), 32'(exp_out.ssd[7]));
        check("SSD6", 32'(SSD6), 32'(exp_out.ssd[6]));
        check("SSD5", 32'(SSD5), 32'(exp_out.ssd[5]));
        check("SSD4", 32'(SSD4), 32'(exp_out.ssd[4]));
        check("SSD3", 32'(SSD3), 32'(exp_out.ssd[3]));
        check("SSD2", 32'(SSD2), 32'(exp_out.ssd[2]));
        check("SSD1", 32'(SSD1), 32'(exp_out.ssd[1]));
        check("SSD0", 32'(SSD0), 32'(exp_out.ssd[0]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        // Reset values.
        rst = 1'b1;
        run(2);
        check("rst_ssd3", 32'(SSD3), 32'(7'b1111111));
        check("rst_leds", 32'({LEDA, LEDB, LEDX}), 32'(0));

        // 1. IDLE blink over two half-periods and into the next ON phase.
        rst = 1'b0; state = 4'd0;
        run(2 * BH + 5);

        // 2. DISPLAY with B serving.
        state = 4'd1; turn = 1'b1; score_a = 3'd2; score_b = 3'd1;
        tick();
        check("disp_ssd3", 32'(SSD3), 32'(7'b0100100));
        check("disp_ssd0", 32'(SSD0), 32'(7'b1111001));
        check("disp_leds", 32'({LEDA, LEDB}), 32'(2'b01));

        // 3. SEND_B with puck in range, then an off-board column.
        state = 4'd5; x_coord = 3'd3; y_coord = 3'd4;
        tick();
        check("send_ledx", 32'(LEDX), 32'(5'b01000));
        check("send_ssd7", 32'(SSD7), 32'(7'b0011001));
        x_coord = 3'd7; y_coord = 3'd6;
        tick();
        check("send_ledx_oob", 32'(LEDX), 32'(0));
        check("send_ssd7_oob", 32'(SSD7), 32'(7'b0111111));

        // 4. GOAL_A blink.
        state = 4'd8; score_a = 3'd1;
        run(2 * BH + 2);

        // 5. GAMEOVER won by B (turn must not matter).
        state = 4'd10; score_a = 3'd1; score_b = 3'd3; turn = 1'b1;
        run(2 * BH + 2);
        // GAMEOVER won by A at exactly the winning score.
        state = 4'd2; tick();
        state = 4'd10; score_a = 3'd3; score_b = 3'd0; turn = 1'b1;
        run(BH + 3);

        // 6. Reset during GOAL_B OFF phase, then restart in GOAL_B.
        state = 4'd9; score_b = 3'd2;
        run(BH + 10);
        rst = 1'b1;
        tick();
        check("midrst_ssd0", 32'(SSD0), 32'(7'b1111111));
        check("midrst_leds", 32'({LEDA, LEDB, LEDX}), 32'(0));
        rst = 1'b0;
        run(BH + 5);

        // Unused state codes.
        state = 4'd13;
        run(BH + 5);

        // Randomized segments: random state held for a random duration.
        for (int seg = 0; seg < 50; seg++) begin
            int hold;
            state = 4'($urandom_range(0, 15));
            hold  = $urandom_range(1, 3 * BH);
            for (int c = 0; c < hold; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    score_a = 3'($urandom_range(0, 7));
                    score_b = 3'($urandom_range(0, 7));
                end
                x_coord = 3'($urandom_range(0, 7));
                y_coord = 3'($urandom_range(0, 7));
                turn    = 1'($urandom_range(0, 1));
                rst     = ($urandom_range(0, 499) == 0);
                tick();
            end
            rst = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
